pipeline_stall_controller: RTL

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

---
 rtl/pipeline_stall_controller_pkg.sv | 15 +
 rtl/pipeline_stall_controller_sat_counter.sv | 24 ++
 rtl/pipeline_stall_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared hazard-unit definitions.
// Holds the stall-controller state encoding and the pipeline address width.
// The hazard detection logic imports the same package, so the encodings
// seen on state_dbg always match what the rest of the hazard logic uses.
package hazard_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Ports:
//   clk     - clock, rising edge
//   reset_n - synchronous active-low reset, clears count
//   inc     - count one event on this edge
//   count   - current value, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall / flush / freeze controller.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RUN        | normal flow; load-use stall, redirect or memory freeze decoded
// LOAD_STALL | one bubble cycle after a load-use stall; stall_req ignored
// MEM_WAIT   | pipeline frozen until mem_busy drops; redirects kept pending
//
// Ports:
//   clk, reset_n                 - clock and synchronous active-low reset
//   stall_req                    - load-use hazard request
//   redirect_req/redirect_target - EX-stage taken branch / jump
//   mem_busy                     - data memory not ready
//   pc_write_en, if_id_write_en  - pipeline register enables
//   if_id_flush, id_ex_bubble    - NOP insertion
//   ex_mem_hold                  - freeze EX/MEM and MEM/WB
//   pc_sel_redirect, redirect_pc - next-PC redirect select and address
//   stall_count, flush_count     - saturating performance counters
//   state_dbg                    - current state encoding
module pipeline_stall_controller #(
  parameter int WORD_SIZE = hazard_pkg::WORD_SIZE,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall_req,
  input  logic                 redirect_req,
  input  logic [WORD_SIZE-1:0] redirect_target,
  input  logic                 mem_busy,
  output logic                 pc_write_en,
  output logic                 if_id_write_en,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 ex_mem_hold,
  output logic                 pc_sel_redirect,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic [1:0]           state_dbg
);

  import hazard_pkg::*;

  state_t               state, state_nx;
  logic                 pend, pend_nx;
  logic [WORD_SIZE-1:0] pend_tgt, pend_tgt_nx;
  logic [WORD_SIZE-1:0] rpc_q;
  logic                 apply;
  logic [WORD_SIZE-1:0] apply_tgt;
  logic                 stall_inc, flush_inc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= RUN;
      pend     <= 1'b0;
      pend_tgt <= '0;
      rpc_q    <= '0;
    end else begin
      state    <= state_nx;
      pend     <= pend_nx;
      pend_tgt <= pend_tgt_nx;
      if (apply) rpc_q <= apply_tgt;
    end
  end

  always_comb begin
    state_nx        = state;
    pend_nx         = pend;
    pend_tgt_nx     = pend_tgt;
    apply           = 1'b0;
    apply_tgt       = redirect_target;
    stall_inc       = 1'b0;
    pc_write_en     = 1'b0;
    if_id_write_en  = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_bubble    = 1'b0;
    ex_mem_hold     = 1'b0;
    pc_sel_redirect = 1'b0;

    // Decode is skipped entirely in reset so every control stays low.
    if (reset_n) begin
      unique case (state)
        RUN, LOAD_STALL: begin
          if (mem_busy) begin
            ex_mem_hold = 1'b1;
            state_nx    = MEM_WAIT;
          end else if (redirect_req) begin
            apply    = 1'b1;
            state_nx = RUN;
          end else if (stall_req && (state == RUN)) begin
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            state_nx     = LOAD_STALL;
          end else begin
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
            state_nx       = RUN;
          end
        end
        MEM_WAIT: begin
          if (mem_busy) begin
            ex_mem_hold = 1'b1;
            if (redirect_req) begin
              pend_nx     = 1'b1;
              pend_tgt_nx = redirect_target;
            end
          end else begin
            state_nx = RUN;
            pend_nx  = 1'b0;
            // A live request is younger than anything pending.
            if (redirect_req) begin
              apply = 1'b1;
            end else if (pend) begin
              apply     = 1'b1;
              apply_tgt = pend_tgt;
            end else begin
              pc_write_en    = 1'b1;
              if_id_write_en = 1'b1;
            end
          end
        end
        default: state_nx = RUN;
      endcase

      if (apply) begin
        pc_sel_redirect = 1'b1;
        pc_write_en     = 1'b1;
        if_id_flush     = 1'b1;
        id_ex_bubble    = 1'b1;
      end
    end
  end

  assign flush_inc   = apply;
  // Bypass only in the redirect cycle; otherwise show the last applied target.
  assign redirect_pc = apply ? apply_tgt : rpc_q;
  assign state_dbg   = state;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall_inc),
    .count   (stall_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (flush_inc),
    .count   (flush_count)
  );

endmodule
